tcdm_bank_ts_adapter: RTL and testbench

TCDM_BANK_TS_ADAPTER -- requirements
Module: tcdm_bank_ts_adapter

---
 rtl/tcdm_bank_pkg.sv | 18 +
 rtl/tcdm_bank_rsp_fifo.sv | 67 ++++++
 rtl/tcdm_bank_ts_adapter.sv | 129 ++++++++++++
 tb/tb_tcdm_bank_ts_adapter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_bank_pkg.sv
// Shared types for the TCDM bank test-and-set adapter.
// FSM state encoding and the response record held in the FIFO.
package tcdm_bank_pkg;

  localparam int unsigned RSP_DW = 32;
  localparam int unsigned RSP_IW = 8;

  typedef enum logic {
    IDLE     = 1'b0,
    TS_WRITE = 1'b1
  } state_e;

  typedef struct packed {
    logic [RSP_DW-1:0] data;
    logic [RSP_IW-1:0] id;
  } rsp_t;

endpackage

// File: rtl/tcdm_bank_rsp_fifo.sv
// Small response buffer between the bank and the interconnect.
// Registered head; the head reads as zero while empty.
module tcdm_bank_rsp_fifo
  import tcdm_bank_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned IW    = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic [IW-1:0] push_id,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic [IW-1:0] pop_id,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  rsp_t          mem [DEPTH];
  rsp_t          head;
  rsp_t          entry;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Widen the incoming response into the shared record layout.
  always_comb begin
    entry      = '0;
    entry.data = RSP_DW'(push_data);
    entry.id   = RSP_IW'(push_id);
  end

  assign pop_data = empty ? '0 : head.data[DW-1:0];
  assign pop_id   = empty ? '0 : head.id[IW-1:0];

  // Ring-buffer pointers, occupancy and storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= entry;
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/tcdm_bank_ts_adapter.sv
// TCDM bank adapter: credit-based grant, 2-deep response buffer,
// and atomic test-and-set as a read followed by an all-ones write.
module tcdm_bank_ts_adapter
  import tcdm_bank_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 11,
  parameter int unsigned IW        = 8,
  parameter bit          WRITE_RSP = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            tcdm_req_i,
  output logic            tcdm_gnt_o,
  input  logic [AW-1:0]   tcdm_add_i,
  input  logic            tcdm_wen_i,
  input  logic [DW-1:0]   tcdm_data_i,
  input  logic [DW/8-1:0] tcdm_be_i,
  input  logic [IW-1:0]   tcdm_id_i,
  input  logic            tcdm_ts_i,
  output logic            tcdm_r_valid_o,
  input  logic            tcdm_r_ready_i,
  output logic [DW-1:0]   tcdm_r_data_o,
  output logic [IW-1:0]   tcdm_r_id_o,
  output logic            tcdm_r_opc_o,
  output logic            sram_req_o,
  output logic            sram_we_o,
  output logic [AW-1:0]   sram_add_o,
  output logic [DW-1:0]   sram_wdata_o,
  output logic [DW/8-1:0] sram_be_o,
  input  logic [DW-1:0]   sram_rdata_i
);

  state_e        state;
  logic          pend_push;
  logic          pend_rd;
  logic [IW-1:0] pend_id;
  logic [AW-1:0] ts_add;
  logic [1:0]    fifo_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic [2:0]    occ;
  logic          credit;
  logic [DW-1:0] push_data;

  assign pop    = tcdm_r_valid_o & tcdm_r_ready_i;
  assign occ    = {1'b0, fifo_cnt} + {2'b0, pend_push} - {2'b0, pop};
  assign credit = (occ < 3'd2) & ~(fifo_full & ~pop);

  assign tcdm_gnt_o = rst_ni & (state == IDLE)
                    & tcdm_req_i & credit;

  assign tcdm_r_valid_o = ~fifo_empty;
  assign tcdm_r_opc_o   = 1'b0;

  // Reads and test-and-set return bank data; writes return zero.
  assign push_data = pend_rd ? sram_rdata_i : '0;

  // Bank port: granted access, or the set half of test-and-set.
  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_add_o   = tcdm_add_i;
    sram_wdata_o = tcdm_data_i;
    sram_be_o    = tcdm_be_i;
    if (rst_ni) begin
      unique case (1'b1)
        (state == TS_WRITE): begin
          sram_req_o   = 1'b1;
          sram_we_o    = 1'b1;
          sram_add_o   = ts_add;
          sram_wdata_o = '1;
          sram_be_o    = '1;
        end
        tcdm_gnt_o: begin
          sram_req_o = 1'b1;
          sram_we_o  = ~tcdm_wen_i;
        end
        default: ;
      endcase
    end
  end

  // FSM plus the one-cycle bookkeeping for responses in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      pend_push <= 1'b0;
      pend_rd   <= 1'b0;
      pend_id   <= '0;
      ts_add    <= '0;
    end else begin
      pend_push <= tcdm_gnt_o & (tcdm_wen_i | WRITE_RSP);
      pend_rd   <= tcdm_gnt_o & tcdm_wen_i;
      if (tcdm_gnt_o) begin
        pend_id <= tcdm_id_i;
        ts_add  <= tcdm_add_i;
      end
      unique case (state)
        IDLE: begin
          if (tcdm_gnt_o & tcdm_wen_i & tcdm_ts_i) begin
            state <= TS_WRITE;
          end
        end
        TS_WRITE: state <= IDLE;
      endcase
    end
  end

  tcdm_bank_rsp_fifo #(
    .DW    (DW),
    .IW    (IW),
    .DEPTH (2)
  ) u_rsp_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (pend_push),
    .push_data (push_data),
    .push_id   (pend_id),
    .pop       (pop),
    .pop_data  (tcdm_r_data_o),
    .pop_id    (tcdm_r_id_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

endmodule

// File: tb/tb_tcdm_bank_ts_adapter.sv
// Directed bench for tcdm_bank_ts_adapter with a behavioural SRAM.
// Table of single transactions plus hand-written multi-cycle sequences.
module tb_tcdm_bank_ts_adapter;

  localparam int DW = 32;
  localparam int AW = 11;
  localparam int IW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req, gnt, wen, ts;
  logic [AW-1:0] add;
  logic [DW-1:0] wdata;
  logic [3:0]    be;
  logic [IW-1:0] id;
  logic          r_valid, r_ready, r_opc;
  logic [DW-1:0] r_data;
  logic [IW-1:0] r_id;
  logic          sram_req, sram_we;
  logic [AW-1:0] sram_add;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic [3:0]    sram_be;

  logic [DW-1:0] mem [2**AW];
  logic          preloaded = 1'b0;
  int            ts50_wr = 0;

  int n_tests = 0;
  int n_fail  = 0;

  tcdm_bank_ts_adapter dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .tcdm_req_i     (req),
    .tcdm_gnt_o     (gnt),
    .tcdm_add_i     (add),
    .tcdm_wen_i     (wen),
    .tcdm_data_i    (wdata),
    .tcdm_be_i      (be),
    .tcdm_id_i      (id),
    .tcdm_ts_i      (ts),
    .tcdm_r_valid_o (r_valid),
    .tcdm_r_ready_i (r_ready),
    .tcdm_r_data_o  (r_data),
    .tcdm_r_id_o    (r_id),
    .tcdm_r_opc_o   (r_opc),
    .sram_req_o     (sram_req),
    .sram_we_o      (sram_we),
    .sram_add_o     (sram_add),
    .sram_wdata_o   (sram_wdata),
    .sram_be_o      (sram_be),
    .sram_rdata_i   (sram_rdata)
  );

  // Behavioural SRAM: preload once, then byte-masked writes, 1-cycle reads.
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
      mem[11'h005] <= 32'hDEADBEEF;
      mem[11'h020] <= 32'hAABBCCDD;
      mem[11'h050] <= 32'h00000055;
      for (int i = 0; i < 4; i++) mem[11'h040 + i] <= 32'hA0A00000 + i;
      preloaded <= 1'b1;
    end else if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_add][8*b +: 8] <= sram_wdata[8*b +: 8];
        if (sram_add == 11'h050) ts50_wr <= ts50_wr + 1;
      end else begin
        sram_rdata <= mem[sram_add];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic t, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [3:0] b,
                       input logic [IW-1:0] i);
    req = 1'b1; wen = w; ts = t; add = a; wdata = d; be = b; id = i;
  endtask

  // Present a request until granted (bounded), then drop it.
  task automatic issue(input logic w, input logic t, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [3:0] b,
                       input logic [IW-1:0] i, input string name);
    logic got;
    got = 1'b0;
    @(negedge clk);
    drive(w, t, a, d, b, i);
    for (int c = 0; c < 30; c++) begin
      #2;
      if (gnt) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (got) @(posedge clk);
    #1 req = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL %s: grant timeout, got none, expected gnt=1", name);
    end
  endtask

  task automatic wait_rsp(output logic [DW-1:0] d, output logic [IW-1:0] i,
                          input string name);
    logic got;
    got = 1'b0; d = '0; i = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (r_valid && r_ready) begin
        d = r_data; i = r_id; got = 1'b1;
        break;
      end
    end
    if (got) begin
      @(posedge clk); #1;
    end else begin
      n_tests++; n_fail++;
      $display("FAIL %s: response timeout, got none, expected r_valid=1", name);
    end
  endtask

  typedef struct {
    logic          w;
    logic          t;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [3:0]    b;
    logic [IW-1:0] i;
    logic [DW-1:0] exp_d;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [DW-1:0] rd;
    logic [IW-1:0] ri;
    logic          g;
    int            idx, ridx;

    //         wen   ts    addr     wdata         be       id     expected data
    vecs[0]  = '{1'b1, 1'b0, 11'h005, 32'h0,        4'hF,  8'h03, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 1'b0, 11'h020, 32'h12345678, 4'h3,  8'h07, 32'h00000000};
    vecs[2]  = '{1'b1, 1'b0, 11'h020, 32'h0,        4'hF,  8'h08, 32'hAABB5678};
    vecs[3]  = '{1'b1, 1'b1, 11'h010, 32'h0,        4'hF,  8'h09, 32'h00000000};
    vecs[4]  = '{1'b1, 1'b1, 11'h010, 32'h0,        4'hF,  8'h0A, 32'hFFFFFFFF};
    vecs[5]  = '{1'b1, 1'b0, 11'h010, 32'h0,        4'hF,  8'h0B, 32'hFFFFFFFF};
    vecs[6]  = '{1'b0, 1'b0, 11'h030, 32'hCAFEF00D, 4'hF,  8'h0C, 32'h00000000};
    vecs[7]  = '{1'b1, 1'b0, 11'h030, 32'h0,        4'hF,  8'h0D, 32'hCAFEF00D};
    vecs[8]  = '{1'b0, 1'b0, 11'h7FF, 32'h11223344, 4'hC,  8'hFE, 32'h00000000};
    vecs[9]  = '{1'b1, 1'b0, 11'h7FF, 32'h0,        4'hF,  8'hFF, 32'h11220000};
    vecs[10] = '{1'b1, 1'b0, 11'h000, 32'h0,        4'hF,  8'h00, 32'h00000000};

    // Reset state, with a request pending that must not be granted.
    rst_n = 1'b0; r_ready = 1'b1;
    drive(1'b1, 1'b0, 11'h005, 32'h0, 4'hF, 8'h01);
    repeat (3) @(negedge clk);
    #2;
    chk("rst gnt", gnt, 0);
    chk("rst r_valid", r_valid, 0);
    chk("rst sram_req", sram_req, 0);
    chk("rst sram_we", sram_we, 0);
    chk("rst r_data", r_data, 0);
    chk("rst r_id", r_id, 0);
    chk("rst r_opc", r_opc, 0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Read latency: grant same cycle, response two cycles later.
    @(negedge clk);
    drive(1'b1, 1'b0, 11'h005, 32'h0, 4'hF, 8'h03);
    #2 chk("lat gnt", gnt, 1);
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    chk("lat r_valid +1", r_valid, 0);
    @(negedge clk);
    chk("lat r_valid +2", r_valid, 1);
    chk("lat r_data", r_data, 32'hDEADBEEF);
    chk("lat r_id", r_id, 8'h03);
    @(negedge clk);
    chk("lat drained", r_valid, 0);

    // Table of single transactions.
    foreach (vecs[k]) begin
      issue(vecs[k].w, vecs[k].t, vecs[k].a, vecs[k].d, vecs[k].b,
            vecs[k].i, $sformatf("vec%0d", k));
      wait_rsp(rd, ri, $sformatf("vec%0d", k));
      chk($sformatf("vec%0d data", k), rd, vecs[k].exp_d);
      chk($sformatf("vec%0d id", k), ri, vecs[k].i);
    end
    chk("ts mem 0x010", mem[11'h010], 32'hFFFFFFFF);

    // TS followed by a held read: no grant during the set write.
    @(negedge clk);
    drive(1'b1, 1'b1, 11'h060, 32'h0, 4'hF, 8'h30);
    #2 chk("ts2 gnt", gnt, 1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 11'h060, 32'h0, 4'hF, 8'h31);
    @(negedge clk); #2;
    chk("ts2 gnt low", gnt, 0);
    chk("ts2 sram_we", sram_we, 1);
    chk("ts2 sram_add", sram_add, 11'h060);
    chk("ts2 sram_wdata", sram_wdata, 32'hFFFFFFFF);
    chk("ts2 sram_be", sram_be, 4'hF);
    @(negedge clk); #2;
    chk("ts2 gnt back", gnt, 1);
    chk("ts2 rsp valid", r_valid, 1);
    chk("ts2 rsp data", r_data, 32'h0);
    chk("ts2 rsp id", r_id, 8'h30);
    @(posedge clk); #1 req = 1'b0;
    wait_rsp(rd, ri, "ts2 read");
    chk("ts2 read data", rd, 32'hFFFFFFFF);
    chk("ts2 read id", ri, 8'h31);

    // Back-pressure: four reads with r_ready low, then release.
    r_ready = 1'b0; idx = 0; ridx = 0;
    for (int cyc = 0; cyc < 40 && ridx < 4; cyc++) begin
      @(negedge clk);
      if (cyc == 5) r_ready = 1'b1;
      if (idx < 4) drive(1'b1, 1'b0, AW'(11'h040 + idx), 32'h0, 4'hF,
                         IW'(8'h10 + idx));
      else req = 1'b0;
      #2;
      g = gnt;
      if (cyc < 5) chk($sformatf("bp gnt c%0d", cyc), g, (cyc < 2) ? 1 : 0);
      if (r_valid && r_ready) begin
        chk($sformatf("bp data %0d", ridx), r_data, 32'hA0A00000 + ridx);
        chk($sformatf("bp id %0d", ridx), r_id, 8'h10 + ridx);
        ridx++;
      end
      if (g) idx++;
    end
    req = 1'b0;
    chk("bp responses", ridx, 4);
    chk("bp grants", idx, 4);

    // Reset landing on the TS write cycle aborts the write.
    @(negedge clk);
    drive(1'b1, 1'b1, 11'h050, 32'h0, 4'hF, 8'h20);
    #2 chk("rts gnt", gnt, 1);
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2 chk("rts sram_req", sram_req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("rts r_valid", r_valid, 0);
    chk("rts mem 0x050", mem[11'h050], 32'h00000055);
    chk("rts writes", ts50_wr, 0);
    issue(1'b1, 1'b0, 11'h050, 32'h0, 4'hF, 8'h21, "rts read");
    wait_rsp(rd, ri, "rts read");
    chk("rts read data", rd, 32'h00000055);
    chk("rts read id", ri, 8'h21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
